alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around the combinational 8-bit ALU.
// Purpose: owns R0..R3 and flags {E,P,Z,B,C}. It accepts one instruction
//   over in_valid/in_ready, registers the operands to the ALU, and writes
//   the ALU result back one cycle later. LDI is executed locally.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      instruction handshake
//   in_opcode/rd/rs/imm    instruction fields
//   alu_a/b/cin/opcode     registered ALU inputs
//   alu_y/cout/borrow/     ALU result and status
//     invalid_op/zero/parity
//   out_valid/out_result   completion pulse and written-back value
//   flags                  {E,P,Z,B,C}
//   dbg_sel/dbg_data       combinational register-file read port
module alu_issue_ctrl #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [1:0]           in_rd,
    input  logic [1:0]           in_rs,
    input  logic [BUS_WIDTH-1:0] in_imm,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_cin,
    output logic [3:0]           alu_opcode,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_cout,
    input  logic                 alu_borrow,
    input  logic                 alu_invalid_op,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic [4:0]           flags,
    input  logic [1:0]           dbg_sel,
    output logic [BUS_WIDTH-1:0] dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam int FE = 4;
    localparam int FP = 3;
    localparam int FZ = 2;
    localparam int FB = 1;
    localparam int FC = 0;

    state_t               state_q;
    logic [BUS_WIDTH-1:0] rf_q [4];
    logic [4:0]           flags_q;
    logic [BUS_WIDTH-1:0] alu_a_q;
    logic [BUS_WIDTH-1:0] alu_b_q;
    logic                 alu_cin_q;
    logic [3:0]           alu_opcode_q;
    logic [BUS_WIDTH-1:0] imm_q;
    logic [1:0]           rd_q;
    logic                 ldi_q;
    logic                 out_valid_q;
    logic [BUS_WIDTH-1:0] out_result_q;

    logic                 wb_en_d;
    logic [BUS_WIDTH-1:0] wb_data_d;
    logic [4:0]           flags_d;
    logic                 arith;

    // Opcodes 1..5 are the carry/borrow producing group.
    assign arith = (alu_opcode_q >= 4'd1) && (alu_opcode_q <= 4'd5);

    always_comb begin
        wb_en_d   = 1'b0;
        wb_data_d = '0;
        flags_d   = flags_q;
        if (ldi_q) begin
            wb_en_d     = 1'b1;
            wb_data_d   = imm_q;
            flags_d[FE] = 1'b0;
            flags_d[FP] = ^imm_q;
            flags_d[FZ] = (imm_q == '0);
        end else if (alu_invalid_op) begin
            flags_d[FE] = 1'b1;
        end else begin
            wb_en_d     = 1'b1;
            wb_data_d   = alu_y;
            flags_d[FE] = 1'b0;
            flags_d[FP] = alu_parity;
            flags_d[FZ] = alu_zero;
            if (arith) begin
                flags_d[FB] = alu_borrow;
                flags_d[FC] = alu_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            flags_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_opcode_q <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            ldi_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q      <= rf_q[in_rd];
                        alu_b_q      <= rf_q[in_rs];
                        alu_cin_q    <= flags_q[FC];
                        alu_opcode_q <= in_opcode;
                        imm_q        <= in_imm;
                        rd_q         <= in_rd;
                        ldi_q        <= (in_opcode == 4'd0);
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // Writeback lands with the return to IDLE, so the
                    // next accept already reads the updated register.
                    if (wb_en_d) rf_q[rd_q] <= wb_data_d;
                    out_result_q <= wb_data_d;
                    flags_q      <= flags_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE) && rst_n;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_opcode = alu_opcode_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign flags      = flags_q;
    assign dbg_data   = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU model.
// Directed vector table plus stream and reset-in-EXEC sequences.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [7:0] in_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic       alu_cout;
    logic       alu_borrow;
    logic       alu_invalid_op;
    logic       alu_zero;
    logic       alu_parity;
    logic       out_valid;
    logic [7:0] out_result;
    logic [4:0] flags;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
        .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_borrow(alu_borrow),
        .alu_invalid_op(alu_invalid_op), .alu_zero(alu_zero),
        .alu_parity(alu_parity),
        .out_valid(out_valid), .out_result(out_result),
        .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Behavioural ALU: carry only from add-type ops, borrow only from subs.
    always_comb begin
        logic [8:0] t;
        t              = '0;
        alu_y          = '0;
        alu_cout       = 1'b0;
        alu_borrow     = 1'b0;
        alu_invalid_op = 1'b0;
        case (alu_opcode)
            4'd1: begin t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = t[7:0]; alu_cout = t[8]; end
            4'd2: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                alu_y = t[7:0]; alu_cout = t[8]; end
            4'd3: begin alu_y = alu_a - alu_b; alu_borrow = alu_a < alu_b; end
            4'd4: begin t = {1'b0, alu_a} + 9'd1;
                alu_y = t[7:0]; alu_cout = t[8]; end
            4'd5: begin alu_y = alu_a - 8'd1; alu_borrow = alu_a == 8'd0; end
            4'd6: alu_y = alu_a & alu_b;
            4'd7: alu_y = ~alu_a;
            4'd8: alu_y = {alu_a[6:0], alu_a[7]};
            4'd9: alu_y = {alu_a[0], alu_a[7:1]};
            4'd0: alu_y = '0;
            default: alu_invalid_op = 1'b1;
        endcase
        alu_zero   = (alu_y == 8'd0);
        alu_parity = ^alu_y;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] res;
        logic [7:0] rval;
        logic [4:0] flg;
    } vec_t;

    vec_t vecs [16];

    task automatic issue(input vec_t v, input logic exp_cin);
        int budget;
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs     = v.rs;
        in_imm    = v.imm;
        dbg_sel   = v.rd;
        budget    = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("alu_cin", {31'd0, alu_cin}, {31'd0, exp_cin});
        chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, v.op});
        chk("exec_valid_lo", {31'd0, out_valid}, 32'd0);
        chk("exec_ready_lo", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_result", {24'd0, out_result}, {24'd0, v.res});
        chk("flags", {27'd0, flags}, {27'd0, v.flg});
        chk("reg_rd", {24'd0, dbg_data}, {24'd0, v.rval});
        @(posedge clk);
        #1;
        chk("pulse_end", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic       cin_e;
        int         pulses;
        vecs[0]  = '{4'h0, 2'd0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 5'h00};
        vecs[1]  = '{4'h0, 2'd1, 2'd0, 8'h01, 8'h01, 8'h01, 5'h08};
        vecs[2]  = '{4'h1, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 5'h05};
        vecs[3]  = '{4'h0, 2'd2, 2'd0, 8'h10, 8'h10, 8'h10, 5'h09};
        vecs[4]  = '{4'h0, 2'd3, 2'd0, 8'h20, 8'h20, 8'h20, 5'h09};
        vecs[5]  = '{4'h2, 2'd2, 2'd3, 8'h00, 8'h31, 8'h31, 5'h08};
        vecs[6]  = '{4'h3, 2'd0, 2'd1, 8'h00, 8'hFF, 8'hFF, 5'h02};
        vecs[7]  = '{4'h5, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 5'h04};
        vecs[8]  = '{4'h3, 2'd1, 2'd0, 8'h00, 8'h01, 8'h01, 5'h0A};
        vecs[9]  = '{4'h0, 2'd2, 2'd0, 8'h81, 8'h81, 8'h81, 5'h02};
        vecs[10] = '{4'h8, 2'd2, 2'd0, 8'h00, 8'h03, 8'h03, 5'h02};
        vecs[11] = '{4'h9, 2'd2, 2'd0, 8'h00, 8'h81, 8'h81, 5'h02};
        vecs[12] = '{4'h7, 2'd2, 2'd0, 8'h00, 8'h7E, 8'h7E, 5'h02};
        vecs[13] = '{4'hC, 2'd3, 2'd0, 8'h00, 8'h00, 8'h20, 5'h12};
        vecs[14] = '{4'h4, 2'd3, 2'd0, 8'h00, 8'h21, 8'h21, 5'h00};
        vecs[15] = '{4'h6, 2'd0, 2'd1, 8'h00, 8'h01, 8'h01, 5'h08};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rd     = '0;
        in_rs     = '0;
        in_imm    = '0;
        dbg_sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {27'd0, flags}, 32'd0);
        chk("rst_result", {24'd0, out_result}, 32'd0);
        chk("rst_alu", {alu_a, alu_b, 3'd0, alu_cin, alu_opcode}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = r[1:0];
            #1;
            chk("rst_reg", {24'd0, dbg_data}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        cin_e = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i], cin_e);
            cin_e = vecs[i].flg[0];
        end

        // Stream: ADD R1,R1 with in_valid held high, R1 = 0x01 doubles 4x.
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 4'h1;
        in_rd     = 2'd1;
        in_rs     = 2'd1;
        dbg_sel   = 2'd1;
        pulses    = 0;
        for (int k = 0; k < 8; k++) begin
            chk("stream_ready", {31'd0, in_ready}, {31'd0, (k % 2) == 0});
            @(negedge clk);
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("stream_pulses", pulses, 32'd4);
        chk("stream_r1", {24'd0, dbg_data}, 32'h10);

        // Reset while an LDI is in EXEC discards it.
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 4'h0;
        in_rd     = 2'd0;
        in_imm    = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_exec_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_exec_flags", {27'd0, flags}, 32'd0);
        chk("rst_exec_ready2", {31'd0, in_ready}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = r[1:0];
            #1;
            chk("rst_exec_reg", {24'd0, dbg_data}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_exec_ready3", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_exec_novalid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
